// File: rtl/dmem_ctrl_pkg.sv
// Shared constants for the data-memory access controller: FSM state encodings
// and the default bus timeout.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_REQ  = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;

  localparam int DMEM_TIMEOUT = 255;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Counts REQ cycles without an acknowledge; expired is asserted while the
// count sits at TIMEOUT-1, i.e. in the last REQ cycle the access may wait.
module dmem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            W    = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: turns a load/store request into a bus
// req/ack transaction, stalls the pipeline until it completes, flags errors.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DMEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_opResult,
  input  logic [31:0] mem_memData,
  input  logic        mem_memWE,
  input  logic        mem_memRE,
  output logic        mem_stall,
  output logic [31:0] mem_loadData,
  output logic        mem_memErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output dmem_state_e fsm_state
);

  // Bus handshake: bus_req rises with addr/we/wdata registered and holds them
  // stable until the edge on which bus_ack is sampled high (that edge completes
  // the transfer, read data valid with it) or the timeout expires. bus_ack
  // seen outside REQ means nothing and is dropped.

  dmem_state_e state, state_nxt;
  logic        acc;
  logic        aligned;
  logic        ctr_clear;
  logic        ctr_en;
  logic        expired;

  assign acc     = mem_memRE | mem_memWE;
  assign aligned = (mem_opResult[1:0] == 2'b00);

  dmem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (ctr_clear),
    .enable  (ctr_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DMEM_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DMEM_IDLE: begin
        if (acc) begin
          state_nxt = aligned ? DMEM_REQ : DMEM_DONE;
        end
      end
      DMEM_REQ: begin
        if (bus_ack || expired) begin
          state_nxt = DMEM_DONE;
        end
      end
      DMEM_DONE: state_nxt = DMEM_IDLE;
      default:   state_nxt = DMEM_IDLE;
    endcase
  end

  always_comb begin
    mem_stall = acc & (state != DMEM_DONE);
    ctr_clear = (state == DMEM_IDLE);
    ctr_en    = (state == DMEM_REQ) && !bus_ack;
    fsm_state = state;
  end

  // An ack in the final allowed REQ cycle still wins over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      mem_loadData <= '0;
      mem_memErr   <= 1'b0;
    end else begin
      case (state)
        DMEM_IDLE: begin
          if (acc && aligned) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_memWE;
            bus_addr  <= mem_opResult;
            bus_wdata <= mem_memData;
          end else if (acc) begin
            mem_memErr <= 1'b1;
          end
        end
        DMEM_REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) begin
              mem_loadData <= bus_rdata;
            end
          end else if (expired) begin
            bus_req    <= 1'b0;
            mem_memErr <= 1'b1;
          end
        end
        DMEM_DONE: mem_memErr <= 1'b0;
        default: begin
          bus_req    <= 1'b0;
          mem_memErr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed cycle-by-cycle bench for dmem_ctrl (TIMEOUT=4): a table of
// per-cycle inputs and hand-computed outputs, plus a variable-wait load.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_opResult = '0;
  logic [31:0] mem_memData  = '0;
  logic        mem_memWE = 1'b0;
  logic        mem_memRE = 1'b0;
  logic        mem_stall;
  logic [31:0] mem_loadData;
  logic        mem_memErr;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  dmem_state_e fsm_state;

  int total = 0;
  int bad   = 0;

  dmem_ctrl #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_opResult (mem_opResult),
    .mem_memData  (mem_memData),
    .mem_memWE    (mem_memWE),
    .mem_memRE    (mem_memRE),
    .mem_stall    (mem_stall),
    .mem_loadData (mem_loadData),
    .mem_memErr   (mem_memErr),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .fsm_state    (fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic        re, we, ack, rst;
    logic [31:0] addr, wdata, rdata;
    dmem_state_e e_state;
    logic        e_stall, e_req, e_we, e_err;
    logic [31:0] e_addr, e_wdata, e_ld;
  } vec_t;

  vec_t vecs[64];
  int   n = 0;

  task automatic r(input logic re, input logic we, input logic [31:0] addr,
                   input logic [31:0] wdata, input logic ack, input logic [31:0] rdata,
                   input logic rs, input dmem_state_e st, input logic stall,
                   input logic req, input logic bwe, input logic [31:0] baddr,
                   input logic [31:0] bwdata, input logic [31:0] ld, input logic err);
    vecs[n].re = re;  vecs[n].we = we;  vecs[n].addr = addr; vecs[n].wdata = wdata;
    vecs[n].ack = ack; vecs[n].rdata = rdata; vecs[n].rst = rs;
    vecs[n].e_state = st; vecs[n].e_stall = stall; vecs[n].e_req = req;
    vecs[n].e_we = bwe; vecs[n].e_addr = baddr; vecs[n].e_wdata = bwdata;
    vecs[n].e_ld = ld; vecs[n].e_err = err;
    n++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input vec_t v);
    mem_memRE = v.re; mem_memWE = v.we; mem_opResult = v.addr; mem_memData = v.wdata;
    bus_ack = v.ack; bus_rdata = v.rdata; rst = v.rst;
  endtask

  task automatic compare(input int i, input vec_t v);
    check($sformatf("row%0d state", i), 32'(fsm_state), 32'(v.e_state));
    check($sformatf("row%0d stall", i), 32'(mem_stall), 32'(v.e_stall));
    check($sformatf("row%0d bus_req", i), 32'(bus_req), 32'(v.e_req));
    check($sformatf("row%0d bus_we", i), 32'(bus_we), 32'(v.e_we));
    check($sformatf("row%0d bus_addr", i), bus_addr, v.e_addr);
    check($sformatf("row%0d bus_wdata", i), bus_wdata, v.e_wdata);
    check($sformatf("row%0d loadData", i), mem_loadData, v.e_ld);
    check($sformatf("row%0d memErr", i), 32'(mem_memErr), 32'(v.e_err));
  endtask

  localparam dmem_state_e I = DMEM_IDLE;
  localparam dmem_state_e Q = DMEM_REQ;
  localparam dmem_state_e D = DMEM_DONE;

  initial begin
    int stalls;
    int reqc;
    bit done;
    logic [31:0] ld_seen;
    logic        err_seen;

    // re we addr wdata ack rdata rst | state stall req we addr wdata ld err
    // idle after reset
    r(0,0,32'h0,32'h0,0,32'h0,0, I,0,0,0,32'h0,32'h0,32'h0,0);
    // zero-wait load at 0x100
    r(1,0,32'h100,32'h0,0,32'h0,0, I,1,0,0,32'h0,32'h0,32'h0,0);
    r(1,0,32'h100,32'h0,1,32'hDEADBEEF,0, Q,1,1,0,32'h100,32'h0,32'h0,0);
    r(1,0,32'h100,32'h0,0,32'h0,0, D,0,0,0,32'h100,32'h0,32'hDEADBEEF,0);
    r(0,0,32'h0,32'h0,0,32'h0,0, I,0,0,0,32'h100,32'h0,32'hDEADBEEF,0);
    // 3-wait store at 0x204; ack lands in the last allowed REQ cycle
    r(0,1,32'h204,32'h12345678,0,32'h0,0, I,1,0,0,32'h100,32'h0,32'hDEADBEEF,0);
    r(0,1,32'h204,32'h12345678,0,32'h0,0, Q,1,1,1,32'h204,32'h12345678,32'hDEADBEEF,0);
    r(0,1,32'h204,32'h12345678,0,32'h0,0, Q,1,1,1,32'h204,32'h12345678,32'hDEADBEEF,0);
    r(0,1,32'h204,32'h12345678,0,32'h0,0, Q,1,1,1,32'h204,32'h12345678,32'hDEADBEEF,0);
    r(0,1,32'h204,32'h12345678,1,32'hCAFEF00D,0, Q,1,1,1,32'h204,32'h12345678,32'hDEADBEEF,0);
    r(0,1,32'h204,32'h12345678,0,32'h0,0, D,0,0,1,32'h204,32'h12345678,32'hDEADBEEF,0);
    r(0,0,32'h0,32'h0,0,32'h0,0, I,0,0,1,32'h204,32'h12345678,32'hDEADBEEF,0);
    // misaligned load at 0x102, then a stray ack in IDLE
    r(1,0,32'h102,32'h0,0,32'h0,0, I,1,0,1,32'h204,32'h12345678,32'hDEADBEEF,0);
    r(1,0,32'h102,32'h0,0,32'h0,0, D,0,0,1,32'h204,32'h12345678,32'hDEADBEEF,1);
    r(0,0,32'h0,32'h0,1,32'h77777777,0, I,0,0,1,32'h204,32'h12345678,32'hDEADBEEF,0);
    // timeout: load at 0x300 with no ack, 4 REQ cycles, late ack ignored
    r(1,0,32'h300,32'h0,0,32'h0,0, I,1,0,1,32'h204,32'h12345678,32'hDEADBEEF,0);
    r(1,0,32'h300,32'h0,0,32'h0,0, Q,1,1,0,32'h300,32'h0,32'hDEADBEEF,0);
    r(1,0,32'h300,32'h0,0,32'h0,0, Q,1,1,0,32'h300,32'h0,32'hDEADBEEF,0);
    r(1,0,32'h300,32'h0,0,32'h0,0, Q,1,1,0,32'h300,32'h0,32'hDEADBEEF,0);
    r(1,0,32'h300,32'h0,0,32'h0,0, Q,1,1,0,32'h300,32'h0,32'hDEADBEEF,0);
    r(1,0,32'h300,32'h0,0,32'h0,0, D,0,0,0,32'h300,32'h0,32'hDEADBEEF,1);
    r(0,0,32'h0,32'h0,0,32'h0,0, I,0,0,0,32'h300,32'h0,32'hDEADBEEF,0);
    r(0,0,32'h0,32'h0,1,32'h11111111,0, I,0,0,0,32'h300,32'h0,32'hDEADBEEF,0);
    r(0,0,32'h0,32'h0,0,32'h0,0, I,0,0,0,32'h300,32'h0,32'hDEADBEEF,0);
    // back-to-back store 0x10 then load 0x14, zero-wait
    r(0,1,32'h10,32'hA5A5A5A5,0,32'h0,0, I,1,0,0,32'h300,32'h0,32'hDEADBEEF,0);
    r(0,1,32'h10,32'hA5A5A5A5,1,32'h0,0, Q,1,1,1,32'h10,32'hA5A5A5A5,32'hDEADBEEF,0);
    r(0,1,32'h10,32'hA5A5A5A5,0,32'h0,0, D,0,0,1,32'h10,32'hA5A5A5A5,32'hDEADBEEF,0);
    r(1,0,32'h14,32'h0,0,32'h0,0, I,1,0,1,32'h10,32'hA5A5A5A5,32'hDEADBEEF,0);
    r(1,0,32'h14,32'h0,1,32'h0BADF00D,0, Q,1,1,0,32'h14,32'h0,32'hDEADBEEF,0);
    r(1,0,32'h14,32'h0,0,32'h0,0, D,0,0,0,32'h14,32'h0,32'h0BADF00D,0);
    r(0,0,32'h0,32'h0,0,32'h0,0, I,0,0,0,32'h14,32'h0,32'h0BADF00D,0);
    // reset in the second REQ cycle, then an orphan ack
    r(1,0,32'h40,32'h0,0,32'h0,0, I,1,0,0,32'h14,32'h0,32'h0BADF00D,0);
    r(1,0,32'h40,32'h0,0,32'h0,0, Q,1,1,0,32'h40,32'h0,32'h0BADF00D,0);
    r(1,0,32'h40,32'h0,0,32'h0,1, Q,1,1,0,32'h40,32'h0,32'h0BADF00D,0);
    r(0,0,32'h0,32'h0,1,32'hFFFFFFFF,0, I,0,0,0,32'h0,32'h0,32'h0,0);
    r(0,0,32'h0,32'h0,0,32'h0,0, I,0,0,0,32'h0,32'h0,32'h0,0);

    // clock/reset
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      compare(i, vecs[i]);
    end

    // load at 0x80 with a responder that waits 2 extra cycles
    @(posedge clk); #1;
    mem_memRE = 1'b1; mem_opResult = 32'h80; bus_rdata = 32'h5A5A0001; bus_ack = 1'b0;
    stalls = 0; reqc = 0; done = 1'b0; ld_seen = '0; err_seen = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (mem_stall) stalls++;
      if (fsm_state == DMEM_DONE) begin
        done = 1'b1;
        ld_seen = mem_loadData;
        err_seen = mem_memErr;
      end
      bus_ack = (fsm_state == DMEM_REQ) && (reqc == 2);
      if (fsm_state == DMEM_REQ) reqc++;
      @(posedge clk); #1;
    end
    mem_memRE = 1'b0; bus_ack = 1'b0;
    check("wait2 reached_done", 32'(done), 32'd1);
    check("wait2 stall_cycles", 32'(stalls), 32'd4);
    check("wait2 loadData", ld_seen, 32'h5A5A0001);
    check("wait2 memErr", 32'(err_seen), 32'd0);
    @(negedge clk);
    check("wait2 back_idle", 32'(fsm_state), 32'(DMEM_IDLE));

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
